// File: rtl/hull_fifo_pkg.sv
// Shared FIFO types package: storage-type encodings, default geometry for
// hull_fifo, and the per-user FIFO type/depth constants of this codebase.
package hull_fifo_pkg;

    // Storage implementation encodings for the TYPE parameter
    localparam int HULL_FIFO_TYPE_FF   = 0;
    localparam int HULL_FIFO_TYPE_BRAM = 1;

    // Default geometry of hull_fifo
    localparam int HULL_FIFO_WIDTH     = 64;
    localparam int HULL_FIFO_LOG_DEPTH = 4;

    // Per-user FIFO type/depth constants
    localparam int CMD_FIFO_TYPE       = HULL_FIFO_TYPE_FF;
    localparam int CMD_FIFO_LOG_DEPTH  = 4;
    localparam int RSP_FIFO_TYPE       = HULL_FIFO_TYPE_BRAM;
    localparam int RSP_FIFO_LOG_DEPTH  = 9;
    localparam int EVT_FIFO_TYPE       = HULL_FIFO_TYPE_FF;
    localparam int EVT_FIFO_LOG_DEPTH  = 3;

endpackage

// File: rtl/hull_fifo_counter64.sv
// counter64: free-running 64-bit event counter with synchronous clear.
// Wraps from 2^64-1 to 0.
module counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        increment,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Next count: add one on each incrementing cycle, natural 64-bit wrap
    always_comb begin
        count_d = count_q;
        if (increment) begin
            count_d = count_q + 64'd1;
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hull_fifo.sv
// hull_fifo: first-word-fall-through synchronous FIFO with occupancy count
// and lifetime write counter. Storage is either a flip-flop array with an
// asynchronous head read, or a block RAM whose registered read port is
// pointed at the next-cycle head address so q still falls through.
module hull_fifo
    import hull_fifo_pkg::*;
#(
    parameter int TYPE      = HULL_FIFO_TYPE_FF,
    parameter int WIDTH     = HULL_FIFO_WIDTH,
    parameter int LOG_DEPTH = HULL_FIFO_LOG_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrreq,
    input  logic [WIDTH-1:0]     data,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   usedw,
    output logic [63:0]          wr_count
);

    localparam int                DEPTH     = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] USED_FULL = (LOG_DEPTH + 1)'(DEPTH);

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   usedw_q, usedw_d;
    logic                 wr_acc;
    logic                 rd_acc;

    // Flags from pre-edge occupancy; requests in a reset cycle are dropped
    always_comb begin
        empty    = (usedw_q == '0);
        full     = (usedw_q == USED_FULL);
        wr_acc   = wrreq & ~full & ~rst;
        rd_acc   = rdreq & ~empty & ~rst;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + (LOG_DEPTH + 1)'(1);
            2'b01:   usedw_d = usedw_q - (LOG_DEPTH + 1)'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all stored entries
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
        end
    end

    assign usedw = usedw_q;

    generate
        if (TYPE == HULL_FIFO_TYPE_BRAM) begin : g_bram
            logic [WIDTH-1:0]     mem [DEPTH];
            logic [WIDTH-1:0]     head_q;
            logic [LOG_DEPTH-1:0] rd_addr;

            // After reset the head is slot 0 regardless of the old pointer
            assign rd_addr = rst ? '0 : rd_ptr_d;

            // RAM write port
            always_ff @(posedge clk) begin
                if (wr_acc) begin
                    mem[wr_ptr_q] <= data;
                end
            end

            // RAM read port fetches the next head; bypass a same-edge write to it
            always_ff @(posedge clk) begin
                if (wr_acc && (wr_ptr_q == rd_addr)) begin
                    head_q <= data;
                end else begin
                    head_q <= mem[rd_addr];
                end
            end

            assign q = head_q;
        end else begin : g_ff
            logic [WIDTH-1:0] mem [DEPTH];

            // Flip-flop array write; contents are never cleared
            always_ff @(posedge clk) begin
                if (wr_acc) begin
                    mem[wr_ptr_q] <= data;
                end
            end

            assign q = mem[rd_ptr_q];
        end
    endgenerate

    counter64 u_wr_count (
        .clk       (clk),
        .rst       (rst),
        .increment (wr_acc),
        .count     (wr_count)
    );

endmodule

// File: tb/tb_hull_fifo.sv
// Randomized bench for hull_fifo: both storage types driven in lockstep and
// compared against a queue-based reference model, plus directed scenarios
// and a standalone wrap check of counter64.
module tb_hull_fifo;

    logic        clk;
    logic        rst;
    logic        wrreq;
    logic [63:0] data;
    logic        rdreq;

    logic [63:0] q_ff,  q_br;
    logic        empty_ff, empty_br;
    logic        full_ff,  full_br;
    logic [4:0]  usedw_ff, usedw_br;
    logic [63:0] wrc_ff,   wrc_br;

    logic        c_rst;
    logic        c_inc;
    logic [63:0] c_count;

    int n_checks;
    int n_errors;

    logic [63:0] model_q[$];
    logic [63:0] model_cnt;

    hull_fifo #(.TYPE(0), .WIDTH(64), .LOG_DEPTH(4)) u_ff (
        .clk(clk), .rst(rst), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_ff), .empty(empty_ff), .full(full_ff), .usedw(usedw_ff),
        .wr_count(wrc_ff)
    );

    hull_fifo #(.TYPE(1), .WIDTH(64), .LOG_DEPTH(4)) u_br (
        .clk(clk), .rst(rst), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_br), .empty(empty_br), .full(full_br), .usedw(usedw_br),
        .wr_count(wrc_br)
    );

    counter64 u_c64 (
        .clk(clk), .rst(c_rst), .increment(c_inc), .count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain queue semantics with a 16-entry capacity
    task automatic model_update();
        bit can_rd;
        bit can_wr;
        if (rst) begin
            model_q.delete();
            model_cnt = 64'd0;
        end else begin
            can_rd = rdreq && (model_q.size() > 0);
            can_wr = wrreq && (model_q.size() < 16);
            if (can_rd) void'(model_q.pop_front());
            if (can_wr) begin
                model_q.push_back(data);
                model_cnt = model_cnt + 64'd1;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] sz;
        sz = 64'(model_q.size());
        check_eq("ff_empty", 64'(empty_ff), (sz == 0) ? 64'd1 : 64'd0);
        check_eq("ff_full",  64'(full_ff),  (sz == 16) ? 64'd1 : 64'd0);
        check_eq("ff_usedw", 64'(usedw_ff), sz);
        check_eq("ff_wrcnt", wrc_ff, model_cnt);
        check_eq("br_empty", 64'(empty_br), (sz == 0) ? 64'd1 : 64'd0);
        check_eq("br_full",  64'(full_br),  (sz == 16) ? 64'd1 : 64'd0);
        check_eq("br_usedw", 64'(usedw_br), sz);
        check_eq("br_wrcnt", wrc_br, model_cnt);
        if (sz != 0) begin
            check_eq("ff_q", q_ff, model_q[0]);
            check_eq("br_q", q_br, model_q[0]);
        end
    endtask

    task automatic cycle(input logic w, input logic [63:0] d,
                         input logic r, input logic rs);
        wrreq = w;
        data  = d;
        rdreq = r;
        rst   = rs;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic check_both_q(input string tag, input logic [63:0] exp);
        check_eq({tag, "_ff"}, q_ff, exp);
        check_eq({tag, "_br"}, q_br, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_cnt = 64'd0;
        wrreq = 1'b0; rdreq = 1'b0; data = '0; rst = 1'b1;
        c_rst = 1'b1; c_inc = 1'b0;

        // Reset then idle
        cycle(1'b0, 64'd0, 1'b0, 1'b1);
        cycle(1'b0, 64'd0, 1'b0, 1'b1);
        c_rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
        check_eq("idle_empty", 64'(empty_ff & empty_br), 64'd1);
        check_eq("idle_full",  64'(full_ff | full_br), 64'd0);
        check_eq("idle_usedw", 64'(usedw_ff | usedw_br), 64'd0);
        check_eq("idle_wrcnt", wrc_ff | wrc_br, 64'd0);

        // Fall-through of 0xA then 0xB
        cycle(1'b1, 64'hA, 1'b0, 1'b0);
        check_both_q("fwft_a", 64'hA);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        check_both_q("fwft_b", 64'hB);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        check_eq("fwft_empty", 64'(empty_ff & empty_br), 64'd1);

        // Fill, overflow attempt, drain
        cycle(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
        check_eq("fill_full",  64'(full_ff & full_br), 64'd1);
        check_eq("fill_usedw", 64'(usedw_ff), 64'd16);
        cycle(1'b1, 64'hFF, 1'b0, 1'b0);
        check_eq("ovf_usedw", 64'(usedw_br), 64'd16);
        for (int i = 1; i <= 16; i++) begin
            check_both_q("drain", 64'(i));
            cycle(1'b0, 64'd0, 1'b1, 1'b0);
        end
        check_eq("drain_empty", 64'(empty_ff & empty_br), 64'd1);
        check_eq("drain_wrcnt", wrc_ff, 64'd16);

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < 16; i++) cycle(1'b1, 64'(100 + i), 1'b0, 1'b0);
        cycle(1'b1, 64'h55, 1'b1, 1'b0);
        check_eq("full_rw_usedw", 64'(usedw_ff), 64'd15);
        check_eq("full_rw_usedw_br", 64'(usedw_br), 64'd15);
        cycle(1'b0, 64'd0, 1'b0, 1'b1);
        cycle(1'b1, 64'h99, 1'b1, 1'b0);
        check_eq("empty_rw_usedw", 64'(usedw_ff), 64'd1);
        check_both_q("empty_rw_q", 64'h99);

        // Reset mid-operation, with requests during the reset cycle
        cycle(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'(200 + i), 1'b0, 1'b0);
        cycle(1'b1, 64'h33, 1'b1, 1'b1);
        check_eq("rst_empty", 64'(empty_ff & empty_br), 64'd1);
        check_eq("rst_usedw", 64'(usedw_ff | usedw_br), 64'd0);
        check_eq("rst_wrcnt", wrc_ff | wrc_br, 64'd0);
        cycle(1'b1, 64'h7, 1'b0, 1'b0);
        check_both_q("rst_q7", 64'h7);

        // Randomized phases with varying read/write pressure
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            int rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 500; i++) begin
                cycle(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                      {$urandom(), $urandom()},
                      ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0);
            end
        end

        // counter64 wrap: preload 2^64-2 then count three times
        @(negedge clk);
        force u_c64.count_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release u_c64.count_q;
        c_inc = 1'b1;
        @(posedge clk); #1;
        check_eq("c64_max", c_count, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        check_eq("c64_wrap", c_count, 64'd0);
        @(posedge clk); #1;
        check_eq("c64_one", c_count, 64'd1);
        c_inc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
